// File: rtl/rs485_pkg.sv
// -----------------------------------------------------------------------------
// rs485_pkg
// Shared definitions for the RS485 slave-side blocks: response-scheduler state
// encoding, default data word, and the on-line frame layout used by the
// frame transmitter and the address-sequence detector.
// No ports (package).
// -----------------------------------------------------------------------------
package rs485_pkg;

  // Response word width and the word sent when nothing is pending.
  localparam int                     RESP_DATA_W     = 16;
  localparam logic [RESP_DATA_W-1:0] RESP_EMPTY_WORD = 16'hFFFF;

  // Scheduler states, plain constants so legacy tools can consume them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARB   = 3'd1;
  localparam state_t ST_PRE   = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;
  localparam state_t ST_POST  = 3'd5;

  // Frame layout on the wire: start, 8 data bits LSB first, address mark, stop.
  // The address mark (9th bit) is 1 for address bytes, 0 for data bytes.
  localparam logic FRAME_START_BIT   = 1'b0;
  localparam logic FRAME_STOP_BIT    = 1'b1;
  localparam int   FRAME_DATA_BITS   = 8;
  localparam logic FRAME_ADDR_MARK   = 1'b1;
  localparam logic FRAME_DATA_MARK   = 1'b0;
  localparam int   FRAME_TOTAL_BITS  = 1 + FRAME_DATA_BITS + 1 + 1;

  // Round-robin successor with wrap, valid for any n (not only powers of 2).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rs485_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rs485_rr_arbiter
// Combinational round-robin pick: searches req_i starting at ptr_i, wrapping
// modulo N_REQ, and reports the first set requester.
// Ports:
//   req_i        [N_REQ]  requesters with a pending word
//   ptr_i        [IDX_W]  index with highest priority this round
//   winner_o     [N_REQ]  one-hot winner (all zero when nothing pending)
//   idx_o        [IDX_W]  winner index (0 when nothing pending)
//   any_valid_o  1        at least one requester was set
// -----------------------------------------------------------------------------
module rs485_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default at the top of the
  // always_comb so no path leaves a value unassigned (which would infer a latch).
  always_comb begin
    winner_o    = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (!any_valid_o && req_i[cand]) begin
        any_valid_o     = 1'b1;
        idx_o           = cand;
        winner_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs485_resp_scheduler.sv
// -----------------------------------------------------------------------------
// rs485_resp_scheduler
// Slave-side response scheduler. On a poll it picks one pending telemetry
// requester round-robin, latches its word, drives the frame transmitter through
// a start/done handshake and owns the RS485 driver enable, including pre- and
// post-transmission guard time. All outputs are registered.
// Ports:
//   clk           in   system clock (rising edge)
//   reset         in   synchronous active-high reset
//   addr_match    in   poll pulse from the sequence detector
//   req           in   [N_REQ] per-requester "word pending"
//   req_data      in   [N_REQ*DATA_W] packed words, requester i at [i*DATA_W +: DATA_W]
//   grant         out  [N_REQ] one-hot pulse: word i latched
//   tx_start      out  start pulse to the frame transmitter
//   tx_word       out  [DATA_W] word to transmit, stable until the next poll
//   tx_done       in   transmitter finished the last stop bit
//   de            out  RS485 driver enable
//   resp_done     out  pulse: response finished and de released
//   timeout_err   out  pulse: tx_done never came, response aborted
//   poll_overrun  out  pulse: poll arrived while busy (ignored)
// -----------------------------------------------------------------------------
module rs485_resp_scheduler
  import rs485_pkg::*;
#(
  parameter int                N_REQ        = 4,
  parameter int                DATA_W       = RESP_DATA_W,
  parameter int                GUARD_PRE    = 2,
  parameter int                GUARD_POST   = 2,
  parameter int                DONE_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] EMPTY_WORD   = RESP_EMPTY_WORD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      addr_match,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_word,
  input  logic                      tx_done,
  output logic                      de,
  output logic                      resp_done,
  output logic                      timeout_err,
  output logic                      poll_overrun
);

  localparam int IDX_W   = $clog2(N_REQ);
  // One shared counter serves the pre guard, the done timeout and the post guard.
  localparam int CNT_MAX = (DONE_TIMEOUT > GUARD_PRE)
                           ? ((DONE_TIMEOUT > GUARD_POST) ? DONE_TIMEOUT : GUARD_POST)
                           : ((GUARD_PRE > GUARD_POST) ? GUARD_PRE : GUARD_POST);
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  tx_word_q, tx_word_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic               de_q, de_d;
  logic               resp_done_q, resp_done_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic [N_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  rs485_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .winner_o    (win_onehot),
    .idx_o       (win_idx),
    .any_valid_o (win_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tx_word_d   = tx_word_q;
    grant_d     = '0;
    resp_done_d = 1'b0;
    timeout_d   = 1'b0;
    // Any poll outside IDLE is dropped and flagged.
    overrun_d   = addr_match && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (addr_match) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_any) begin
          tx_word_d = req_data[int'(win_idx)*DATA_W +: DATA_W];
          grant_d   = win_onehot;
          ptr_d     = IDX_W'(rr_next(int'(win_idx), N_REQ));
        end else begin
          tx_word_d = EMPTY_WORD;
        end
        cnt_d   = '0;
        state_d = (GUARD_PRE == 0) ? ST_START : ST_PRE;
      end
      ST_PRE: begin
        if (cnt_q == CNT_W'(GUARD_PRE - 1)) state_d = ST_START;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      ST_START: begin
        // Counter holds cycles elapsed since tx_start; the START cycle is the first.
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done is tested first so it wins over a coincident expiry.
        if (tx_done || (cnt_q >= CNT_W'(DONE_TIMEOUT - 1))) begin
          timeout_d   = !tx_done;
          cnt_d       = '0;
          state_d     = (GUARD_POST == 0) ? ST_IDLE : ST_POST;
          resp_done_d = (GUARD_POST == 0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POST: begin
        if (cnt_q == CNT_W'(GUARD_POST - 1)) begin
          state_d     = ST_IDLE;
          resp_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs decoded from the next state, so they line up with it.
    tx_start_d = (state_d == ST_START);
    de_d       = (state_d == ST_PRE) || (state_d == ST_START) ||
                 (state_d == ST_WAIT) || (state_d == ST_POST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      tx_word_q   <= '0;
      grant_q     <= '0;
      tx_start_q  <= 1'b0;
      de_q        <= 1'b0;
      resp_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tx_word_q   <= tx_word_d;
      grant_q     <= grant_d;
      tx_start_q  <= tx_start_d;
      de_q        <= de_d;
      resp_done_q <= resp_done_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign grant        = grant_q;
  assign tx_start     = tx_start_q;
  assign tx_word      = tx_word_q;
  assign de           = de_q;
  assign resp_done    = resp_done_q;
  assign timeout_err  = timeout_q;
  assign poll_overrun = overrun_q;

endmodule

// File: tb/tb_rs485_resp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rs485_resp_scheduler
// Scoreboard bench: each transaction pushes the events it should cause
// (grant, tx_start, poll_overrun, timeout_err, resp_done) with their cycle and
// output values; a monitor on the falling edge pops and compares every event
// the DUT presents. Any extra or missing event is reported.
// -----------------------------------------------------------------------------
module tb_rs485_resp_scheduler;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;

  localparam int EV_GRANT = 0;
  localparam int EV_START = 1;
  localparam int EV_OVR   = 2;
  localparam int EV_TMO   = 3;
  localparam int EV_DONE  = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  grant;
    logic [15:0] word;
    logic        de;
  } ev_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     addr_match;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         grant;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_word;
  logic                     tx_done;
  logic                     de;
  logic                     resp_done;
  logic                     timeout_err;
  logic                     poll_overrun;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  rs485_resp_scheduler #(
    .N_REQ        (N_REQ),
    .DATA_W       (DATA_W),
    .GUARD_PRE    (2),
    .GUARD_POST   (2),
    .DONE_TIMEOUT (64),
    .EMPTY_WORD   (16'hFFFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_match   (addr_match),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .tx_start     (tx_start),
    .tx_word      (tx_word),
    .tx_done      (tx_done),
    .de           (de),
    .resp_done    (resp_done),
    .timeout_err  (timeout_err),
    .poll_overrun (poll_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required end before limit", cyc);
    $fatal(1, "watchdog");
  end

  function automatic string kind_name(input int k);
    case (k)
      EV_GRANT: return "grant";
      EV_START: return "tx_start";
      EV_OVR:   return "poll_overrun";
      EV_TMO:   return "timeout_err";
      EV_DONE:  return "resp_done";
      default:  return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [3:0] g,
                      input logic [15:0] w, input logic d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.grant = g; e.word = w; e.de = d;
    exp_q.push_back(e);
  endtask

  task automatic match(input ev_t obs);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected %s at cyc %0d: grant=%b word=%h de=%b, none expected",
               kind_name(obs.kind), obs.cyc, obs.grant, obs.word, obs.de);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != obs.kind || e.cyc != obs.cyc || e.grant !== obs.grant ||
          e.word !== obs.word || e.de !== obs.de) begin
        failures++;
        $display("FAIL event: got %s cyc=%0d grant=%b word=%h de=%b, expected %s cyc=%0d grant=%b word=%h de=%b",
                 kind_name(obs.kind), obs.cyc, obs.grant, obs.word, obs.de,
                 kind_name(e.kind), e.cyc, e.grant, e.word, e.de);
      end
    end
  endtask

  // Monitor: every output pulse becomes an observed event, compared in order.
  always @(negedge clk) begin
    ev_t o;
    if (reset !== 1'b1) begin
      o.cyc = cyc; o.grant = grant; o.word = tx_word; o.de = de;
      if (grant != '0)   begin o.kind = EV_GRANT; match(o); end
      if (tx_start)      begin o.kind = EV_START; match(o); end
      if (poll_overrun)  begin o.kind = EV_OVR;   match(o); end
      if (timeout_err)   begin o.kind = EV_TMO;   match(o); end
      if (resp_done)     begin o.kind = EV_DONE;  match(o); end
    end
  end

  // Advance to the drive point (#1 after the edge) of cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One poll. done_off: cycle offset of tx_done from the poll, or -1 for none.
  // ovr_off: offset of an extra poll during the response, or -1.
  task automatic txn(input logic [3:0] req_v, input logic [3:0] exp_g,
                     input logic [15:0] exp_w, input int done_off, input int ovr_off);
    int t;
    int end_c;
    t   = cyc;
    req = req_v;
    if (exp_g != 4'b0000) push(EV_GRANT, t + 2, exp_g, exp_w, 1'b1);
    push(EV_START, t + 4, 4'b0000, exp_w, 1'b1);
    if (ovr_off > 0) push(EV_OVR, t + ovr_off + 1, 4'b0000, exp_w, 1'b1);
    if (done_off < 0) begin
      // tx_start at t+4; timeout visible 64 cycles later, then 2 guard cycles.
      push(EV_TMO, t + 68, 4'b0000, exp_w, 1'b1);
      end_c = t + 70;
    end else begin
      end_c = t + done_off + 3;
    end
    push(EV_DONE, end_c, 4'b0000, exp_w, 1'b0);

    addr_match = 1'b1;
    goto(t + 1);
    addr_match = 1'b0;
    if (ovr_off > 0) begin
      goto(t + ovr_off);
      addr_match = 1'b1;
      goto(t + ovr_off + 1);
      addr_match = 1'b0;
    end
    if (done_off >= 0) begin
      goto(t + done_off);
      tx_done = 1'b1;
      goto(t + done_off + 1);
      tx_done = 1'b0;
    end
    goto(end_c + 2);
  endtask

  initial begin
    int t;
    reset      = 1'b1;
    addr_match = 1'b0;
    req        = '0;
    tx_done    = 1'b0;
    req_data   = {16'h4444, 16'hA55A, 16'h2222, 16'h1111};
    repeat (3) @(posedge clk);
    #1;
    check("reset grant",        32'(grant),        32'h0);
    check("reset tx_start",     32'(tx_start),     32'h0);
    check("reset tx_word",      32'(tx_word),      32'h0);
    check("reset de",           32'(de),           32'h0);
    check("reset resp_done",    32'(resp_done),    32'h0);
    check("reset timeout_err",  32'(timeout_err),  32'h0);
    check("reset poll_overrun", 32'(poll_overrun), 32'h0);
    reset = 1'b0;
    goto(cyc + 2);

    // tx_done while idle must be ignored (monitor flags any resulting event).
    tx_done = 1'b1;
    goto(cyc + 1);
    tx_done = 1'b0;
    goto(cyc + 2);

    // Round-robin with all requesters pending; pointer starts at 0.
    txn(4'b1111, 4'b0001, 16'h1111, 30, -1);
    txn(4'b1111, 4'b0010, 16'h2222, 30, -1);
    txn(4'b1111, 4'b0100, 16'hA55A, 30, -1);
    txn(4'b1111, 4'b1000, 16'h4444, 30, -1);
    txn(4'b1111, 4'b0001, 16'h1111, 30, -1);   // wraps, pointer now 1

    // Single requester 2; pointer becomes 3.
    txn(4'b0100, 4'b0100, 16'hA55A, 30, -1);

    // Nothing pending: empty word, no grant, pointer stays 3.
    txn(4'b0000, 4'b0000, 16'hFFFF, 20, -1);
    txn(4'b1111, 4'b1000, 16'h4444, 20, -1);   // proves pointer was 3; now 0

    // Missing tx_done: timeout path. Pointer 0 -> requester 1 wins, pointer 2.
    txn(4'b0010, 4'b0010, 16'h2222, -1, -1);

    // tx_done on the expiry cycle (t+67 = tx_start+63) plus a poll during WAIT.
    txn(4'b0000, 4'b0000, 16'hFFFF, 67, 10);

    // Reset in WAIT: pointer 2 -> grant requester 2, then reset.
    t   = cyc;
    req = 4'b1111;
    push(EV_GRANT, t + 2, 4'b0100, 16'hA55A, 1'b1);
    push(EV_START, t + 4, 4'b0000, 16'hA55A, 1'b1);
    addr_match = 1'b1;
    goto(t + 1);
    addr_match = 1'b0;
    goto(t + 10);
    check("de high in WAIT", 32'(de), 32'h1);
    reset = 1'b1;
    goto(t + 11);
    check("mid reset de",        32'(de),        32'h0);
    check("mid reset tx_start",  32'(tx_start),  32'h0);
    check("mid reset resp_done", 32'(resp_done), 32'h0);
    check("mid reset tx_word",   32'(tx_word),   32'h0);
    reset = 1'b0;
    goto(t + 14);

    // Pointer reset to 0: requester 0 first.
    txn(4'b1111, 4'b0001, 16'h1111, 30, -1);

    goto(cyc + 5);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs485_resp_scheduler.md
Name: rs485_resp_scheduler

Overview:
- Slave-side response scheduler for the RS485 link.
- When the address-sequence detector reports a poll, it picks one pending telemetry requester round-robin and latches its 16-bit word.
- It then drives the shared bit-serial frame transmitter through a start/done handshake and owns the RS485 driver-enable, including pre- and post-transmission guard time.
- It sits between the sequence detector, N telemetry sources and the frame transmitter.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_W, 16: word width sent per response (two 8-bit frames on the line).
- GUARD_PRE, 2: cycles de is high before tx_start (0 allowed).
- GUARD_POST, 2: cycles de stays high after tx_done (0 allowed).
- DONE_TIMEOUT, 64: maximum cycles from tx_start to tx_done before abort.
- EMPTY_WORD, 16'hFFFF: word sent when no requester is pending.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_match  in  1  one-cycle pulse from the sequence detector: this slave was polled.
- req  in  N_REQ  per-requester "word pending"; held until the matching grant.
- req_data  in  N_REQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W].
- grant  out  N_REQ  one-hot, one-cycle pulse: word i was latched.
- tx_start  out  1  one-cycle pulse to the frame transmitter.
- tx_word  out  DATA_W  word to transmit; stable from grant until the next poll.
- tx_done  in  1  one-cycle pulse from the transmitter: last stop bit sent.
- de  out  1  RS485 driver enable.
- resp_done  out  1  one-cycle pulse: response cycle finished and de released.
- timeout_err  out  1  one-cycle pulse: tx_done was missing, response aborted.
- poll_overrun  out  1  one-cycle pulse: addr_match arrived while not IDLE.

Behaviour:
- Reset: all outputs 0, tx_word=0, rr pointer=0, state IDLE.
  - Reset mid-operation: de and every pulse output drop at the next edge, with no resp_done.
- All outputs are registered.
- States: IDLE, ARB, PRE, START, WAIT, POST.
- IDLE:
  - addr_match=1 -> ARB.
  - While not in IDLE, addr_match is ignored and poll_overrun pulses for one cycle.
- ARB (exactly 1 cycle):
  - Search req starting at the rr pointer, wrapping.
  - Winner i: tx_word<=req_data[i], grant[i]<=1 for one cycle, pointer<=(i+1) mod N_REQ.
  - No req set: tx_word<=EMPTY_WORD, grant stays 0, pointer unchanged.
  - In both cases de<=1.
  - Next state is PRE, or START directly if GUARD_PRE=0.
- PRE: hold de=1 for GUARD_PRE cycles -> START.
- START: tx_start=1 for one cycle; clear the timeout counter -> WAIT.
- WAIT:
  - tx_done=1 -> POST.
  - Counter reaches DONE_TIMEOUT -> POST with timeout_err pulse.
  - tx_done in the same cycle the counter expires: done wins, no timeout_err.
  - tx_done outside WAIT is ignored.
- POST:
  - Hold de=1 for GUARD_POST cycles.
  - Then de<=0 and resp_done pulses in the same cycle; state -> IDLE.
  - GUARD_POST=0 means de falls the cycle after tx_done.
- Timing relative to addr_match sampled at cycle t:
  - grant, tx_word and de become valid at t+2.
  - tx_start goes high at t+2+GUARD_PRE.
- req and req_data are sampled only in ARB; a requester that drops req before its grant is skipped with no error.
- Pointer arithmetic wraps modulo N_REQ, including non-power-of-2 values.

Decomposition:
- Package rs485_pkg holds:
  - state enum;
  - EMPTY_WORD default;
  - DATA_W;
  - frame constants (start, stop, address-byte layout) shared with the transmitter and detector.
- Sub-module rs485_rr_arbiter:
  - combinational round-robin pick from req and the pointer;
  - outputs: one-hot winner, index, any_valid.
  - The scheduler registers the results.

Test Plan:
- Single requester: req=4'b0100, data2=16'hA55A, addr_match at t.
  - Expected: grant=4'b0100 and de=1 at t+2; tx_start at t+4; tx_word=16'hA55A.
  - Drive tx_done at t+30: de falls and resp_done pulses at t+33.
- Round-robin: req=4'b1111 held, four polls.
  - Expected grants in order 0001, 0010, 0100, 1000; a fifth poll grants 0001 again.
- No data: req=0, poll.
  - Expected: no grant; tx_word=16'hFFFF; tx_start still pulses; pointer unchanged.
- Timeout: never assert tx_done.
  - Expected: timeout_err pulses 64 cycles after tx_start; de falls after GUARD_POST cycles; resp_done pulses.
- Boundary: tx_done coincident with timeout expiry -> no timeout_err.
  - Second addr_match during WAIT -> poll_overrun pulses and the state is unaffected.
- Reset asserted in WAIT with de=1.
  - Expected: de=0 at the next edge, no resp_done, pointer=0.
  - The next poll grants requester 0 first.
